// File: rtl/uart_cmd_parser.sv
// Assembles 6-byte SYNC/OPCODE/ADDR_HI/ADDR_LO/DATA/CHK frames from the UART byte stream,
// checks the XOR checksum and inter-byte timeout, and offers good commands on valid/ready.
module uart_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hAA,
  parameter int unsigned TIMEOUT_CLKS = 3480
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic        o_Cmd_Valid,
  input  logic        i_Cmd_Ready,
  output logic [7:0]  o_Cmd_Opcode,
  output logic [15:0] o_Cmd_Addr,
  output logic [7:0]  o_Cmd_Data,
  output logic        o_Chk_Err,
  output logic        o_Timeout_Err,
  output logic        o_Overrun_Err,
  output logic        o_Busy
);

  localparam int unsigned    CNT_W    = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    S_SYNC, S_OPCODE, S_ADDR_HI, S_ADDR_LO, S_DATA, S_CHK, S_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       csum_q, csum_d;
  logic [7:0]       opcode_q, opcode_d;
  logic [7:0]       addr_hi_q, addr_hi_d;
  logic [7:0]       addr_lo_q, addr_lo_d;
  logic [7:0]       data_q, data_d;
  logic             latch_d;
  logic             chk_err_d, timeout_err_d, overrun_err_d;

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) state_q <= S_SYNC;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    csum_d        = csum_q;
    opcode_d      = opcode_q;
    addr_hi_d     = addr_hi_q;
    addr_lo_d     = addr_lo_q;
    data_d        = data_q;
    latch_d       = 1'b0;
    chk_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    overrun_err_d = 1'b0;

    unique case (state_q)
      S_SYNC: begin
        if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) begin
          state_d = S_OPCODE;
          csum_d  = '0;
        end
      end
      S_OPCODE: begin
        if (i_Rx_DV) begin
          opcode_d = i_Rx_Byte;
          csum_d   = csum_q ^ i_Rx_Byte;
          state_d  = S_ADDR_HI;
        end
      end
      S_ADDR_HI: begin
        if (i_Rx_DV) begin
          addr_hi_d = i_Rx_Byte;
          csum_d    = csum_q ^ i_Rx_Byte;
          state_d   = S_ADDR_LO;
        end
      end
      S_ADDR_LO: begin
        if (i_Rx_DV) begin
          addr_lo_d = i_Rx_Byte;
          csum_d    = csum_q ^ i_Rx_Byte;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (i_Rx_DV) begin
          data_d  = i_Rx_Byte;
          csum_d  = csum_q ^ i_Rx_Byte;
          state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte == csum_q) begin
            latch_d = 1'b1;
            state_d = S_HOLD;
          end else begin
            chk_err_d = 1'b1;
            state_d   = S_SYNC;
          end
        end
      end
      S_HOLD: begin
        // A byte landing on the handshake cycle is judged as if already back in S_SYNC
        if (i_Cmd_Ready) begin
          state_d = S_SYNC;
          if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) begin
            state_d = S_OPCODE;
            csum_d  = '0;
          end
        end else if (i_Rx_DV) begin
          overrun_err_d = 1'b1;
        end
      end
      default: state_d = S_SYNC;
    endcase

    // Inter-byte timeout; an arriving byte always beats expiry
    if (state_q inside {S_OPCODE, S_ADDR_HI, S_ADDR_LO, S_DATA, S_CHK} && !i_Rx_DV) begin
      if (cnt_q == CNT_LAST) begin
        timeout_err_d = 1'b1;
        state_d       = S_SYNC;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      cnt_q         <= '0;
      csum_q        <= '0;
      opcode_q      <= '0;
      addr_hi_q     <= '0;
      addr_lo_q     <= '0;
      data_q        <= '0;
      o_Cmd_Valid   <= 1'b0;
      o_Cmd_Opcode  <= '0;
      o_Cmd_Addr    <= '0;
      o_Cmd_Data    <= '0;
      o_Chk_Err     <= 1'b0;
      o_Timeout_Err <= 1'b0;
      o_Overrun_Err <= 1'b0;
      o_Busy        <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      csum_q        <= csum_d;
      opcode_q      <= opcode_d;
      addr_hi_q     <= addr_hi_d;
      addr_lo_q     <= addr_lo_d;
      data_q        <= data_d;
      o_Cmd_Valid   <= (state_d == S_HOLD);
      o_Chk_Err     <= chk_err_d;
      o_Timeout_Err <= timeout_err_d;
      o_Overrun_Err <= overrun_err_d;
      o_Busy        <= (state_d != S_SYNC);
      if (latch_d) begin
        o_Cmd_Opcode <= opcode_q;
        o_Cmd_Addr   <= {addr_hi_q, addr_lo_q};
        o_Cmd_Data   <= data_q;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: directed frames push expected commands/error events,
// a negedge monitor pops and compares whenever the DUT presents a handshake or error pulse.
module tb_uart_cmd_parser;

  localparam int unsigned T = 3480;
  localparam int EV_CHK = 1;
  localparam int EV_TO  = 2;
  localparam int EV_OVR = 3;

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] addr;
    logic [7:0]  data;
  } cmd_t;

  logic        i_Clock = 1'b0;
  logic        i_Reset_n = 1'b0;
  logic        i_Rx_DV = 1'b0;
  logic [7:0]  i_Rx_Byte = 8'h00;
  logic        i_Cmd_Ready = 1'b1;
  logic        o_Cmd_Valid;
  logic [7:0]  o_Cmd_Opcode;
  logic [15:0] o_Cmd_Addr;
  logic [7:0]  o_Cmd_Data;
  logic        o_Chk_Err, o_Timeout_Err, o_Overrun_Err, o_Busy;

  cmd_t cmd_q[$];
  int   err_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  uart_cmd_parser #(.SYNC_BYTE(8'hAA), .TIMEOUT_CLKS(T)) dut (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n), .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte),
    .o_Cmd_Valid(o_Cmd_Valid), .i_Cmd_Ready(i_Cmd_Ready), .o_Cmd_Opcode(o_Cmd_Opcode),
    .o_Cmd_Addr(o_Cmd_Addr), .o_Cmd_Data(o_Cmd_Data), .o_Chk_Err(o_Chk_Err),
    .o_Timeout_Err(o_Timeout_Err), .o_Overrun_Err(o_Overrun_Err), .o_Busy(o_Busy)
  );

  always #5 i_Clock = ~i_Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_err(input int kind, input string name);
    if (err_q.size() == 0) check({"unexpected_", name}, 32'(kind), 32'd0);
    else check(name, 32'(kind), 32'(err_q.pop_front()));
  endtask

  // Monitor: outputs are registered, so sample mid-cycle
  always @(negedge i_Clock) begin
    if (i_Reset_n) begin
      if (o_Cmd_Valid && i_Cmd_Ready) begin
        if (cmd_q.size() == 0) check("unexpected_cmd", {o_Cmd_Opcode, o_Cmd_Addr, o_Cmd_Data}, 32'd0);
        else check("cmd_payload", {o_Cmd_Opcode, o_Cmd_Addr, o_Cmd_Data}, cmd_q.pop_front());
      end
      if (o_Chk_Err)     pop_err(EV_CHK, "chk_err");
      if (o_Timeout_Err) pop_err(EV_TO,  "timeout_err");
      if (o_Overrun_Err) pop_err(EV_OVR, "overrun_err");
    end
  end

  // All drivers start and end 1ns after a rising edge
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_Clock);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = b;
    @(posedge i_Clock);
    #1;
    i_Rx_DV = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] ah, input logic [7:0] al,
                            input logic [7:0] d, input logic [7:0] ck);
    send(8'hAA); send(op); send(ah); send(al); send(d); send(ck);
  endtask

  task automatic push_cmd(input logic [7:0] op, input logic [15:0] addr, input logic [7:0] d);
    cmd_t c;
    c.op = op; c.addr = addr; c.data = d;
    cmd_q.push_back(c);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_flags"}, 32'({o_Cmd_Valid, o_Chk_Err, o_Timeout_Err, o_Overrun_Err, o_Busy}), 32'd0);
    check({name, "_payload"}, {o_Cmd_Opcode, o_Cmd_Addr, o_Cmd_Data}, 32'd0);
  endtask

  initial begin
    idle(3);
    check_quiet("reset");
    i_Reset_n = 1'b1;
    idle(2);

    // 1: good frame, ready high, valid exactly one cycle after the CHK strobe
    push_cmd(8'h01, 16'h1234, 8'h5A);
    send_frame(8'h01, 8'h12, 8'h34, 8'h5A, 8'h7D);
    check("t1_valid_latency", 32'(o_Cmd_Valid), 32'd1);
    idle(1);
    check("t1_valid_one_cycle", 32'(o_Cmd_Valid), 32'd0);
    idle(3);

    // 2: bad checksum
    err_q.push_back(EV_CHK);
    send_frame(8'h01, 8'h12, 8'h34, 8'h5A, 8'h7C);
    check("t2_chk_pulse", 32'(o_Chk_Err), 32'd1);
    check("t2_busy", 32'(o_Busy), 32'd0);
    check("t2_valid", 32'(o_Cmd_Valid), 32'd0);
    idle(3);

    // 3: leading junk is discarded
    push_cmd(8'h02, 16'h0010, 8'hFF);
    send(8'h55);
    check("t3_junk_not_busy", 32'(o_Busy), 32'd0);
    send(8'h3C);
    send_frame(8'h02, 8'h00, 8'h10, 8'hFF, 8'hED);
    idle(3);

    // 4a: timeout after TIMEOUT_CLKS idle clocks, then a good frame
    err_q.push_back(EV_TO);
    send(8'hAA); send(8'h01);
    idle(T - 1);
    check("t4_no_early_timeout", 32'(o_Timeout_Err), 32'd0);
    check("t4_busy_before", 32'(o_Busy), 32'd1);
    idle(1);
    check("t4_timeout_pulse", 32'(o_Timeout_Err), 32'd1);
    check("t4_busy_after", 32'(o_Busy), 32'd0);
    idle(2);
    push_cmd(8'h10, 16'hABCD, 8'h01);
    send_frame(8'h10, 8'hAB, 8'hCD, 8'h01, 8'h77);
    idle(3);

    // 4b: byte on the expiry cycle wins
    push_cmd(8'h20, 16'h0030, 8'h04);
    send(8'hAA); send(8'h20);
    idle(T - 1);
    send(8'h00);
    check("t4_expiry_byte_wins", 32'(o_Timeout_Err), 32'd0);
    send(8'h30); send(8'h04); send(8'h14);
    idle(3);

    // 5: overrun while held, then retire on the same cycle as the next SYNC
    i_Cmd_Ready = 1'b0;
    push_cmd(8'h05, 16'hA0B0, 8'hC0);
    send_frame(8'h05, 8'hA0, 8'hB0, 8'hC0, 8'hD5);
    idle(2);
    err_q.push_back(EV_OVR);
    send(8'h11);
    check("t5_overrun_pulse", 32'(o_Overrun_Err), 32'd1);
    check("t5_payload_held", {o_Cmd_Opcode, o_Cmd_Addr, o_Cmd_Data}, 32'h05A0B0C0);
    idle(2);
    push_cmd(8'h06, 16'h0102, 8'h03);
    i_Cmd_Ready = 1'b1;
    send(8'hAA);
    check("t5_retired", 32'(o_Cmd_Valid), 32'd0);
    check("t5_next_frame_busy", 32'(o_Busy), 32'd1);
    send(8'h06); send(8'h01); send(8'h02); send(8'h03); send(8'h06);
    idle(3);

    // 6: reset mid-frame, then a fresh frame
    send(8'hAA); send(8'h01); send(8'h12);
    i_Reset_n = 1'b0;
    idle(2);
    check_quiet("t6_reset");
    i_Reset_n = 1'b1;
    idle(1);
    push_cmd(8'h01, 16'h1234, 8'h5A);
    send_frame(8'h01, 8'h12, 8'h34, 8'h5A, 8'h7D);
    idle(5);

    check("cmd_queue_drained", 32'(cmd_q.size()), 32'd0);
    check("err_queue_drained", 32'(err_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
